// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Iterative multiply/divide sequencer that owns the HI/LO register pair.
// It sits next to the ALU and is started by decode for the R-type
// mult/multu/div/divu/mfhi/mflo/mthi/mtlo funcs. A multiply runs 32
// shift-add steps and a divide runs 32 restoring steps. A final FIXUP
// step restores signs and writes HI/LO. While an operation is in flight,
// any new HI/LO request stalls the front end.
//
// Ports:
//   clk_in      - clock; all state changes on the rising edge
//   reset_in    - synchronous, active-high reset
//   start_in    - decoded instruction targets this block this cycle
//   func_in     - R-type func field selecting the operation
//   rs_data_in  - multiplicand / dividend / mthi-mtlo source
//   rt_data_in  - multiplier / divisor
//   busy_out    - operation in flight (state != IDLE)
//   stall_out   - start_in while busy; decode holds PC and instruction
//   done_out    - one-cycle pulse after HI/LO take a mult/div result
//   hi_out      - HI register
//   lo_out      - LO register
//   result_out  - mfhi/mflo write-back data (func_in[1] selects LO)
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    // Iteration count; the datapath assumes one bit per step, so this must
    // equal WIDTH.
    parameter int STEPS = 32
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [5:0]       func_in,
    input  logic [WIDTH-1:0] rs_data_in,
    input  logic [WIDTH-1:0] rt_data_in,
    output logic             busy_out,
    output logic             stall_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] result_out
);

    // R-type func encodings handled here
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    localparam int            CW        = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIXUP
    } state_t;

    state_t               state;
    logic [CW-1:0]        step_cnt;

    // Multiply datapath: the product accumulates in the upper half and is
    // shifted right each step, so after STEPS steps it holds the full result.
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   prod;

    // Divide datapath: quo starts as the dividend. Its MSB shifts into the
    // remainder while quotient bits shift in at the LSB.
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     rs_raw;
    logic                 div_zero;

    // Sign bookkeeping for the FIXUP step
    logic                 is_div;
    logic                 neg;
    logic                 qneg;
    logic                 rneg;

    // Per-step combinational results
    logic                 signed_op;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_diff;

    // Absolute value for signed operations; unsigned operands pass through raw.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // Decode-side outputs are purely combinational. Decode needs the stall
    // and the move-from data in the same cycle it presents the instruction.
    assign busy_out   = (state != IDLE);
    assign stall_out  = start_in & busy_out;
    assign result_out = func_in[1] ? lo_out : hi_out;

    // One shift-add step and one restoring-divide step, computed from the
    // current registers. The sequential block commits only the one that
    // matches the state.
    always_comb begin
        signed_op  = (func_in == FUNC_MULT) || (func_in == FUNC_DIV);
        mul_addend = mplier[0] ? mcand : '0;
        mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        div_shift  = {rem, quo[WIDTH-1]};
        div_fits   = (div_shift >= {1'b0, divisor});
        // When the trial fits, the true difference is below the divisor, so
        // dropping the top bit loses nothing.
        div_diff   = div_shift[WIDTH-1:0] - divisor;
    end

    // Sequencer: accept requests in IDLE, iterate in MUL/DIV, then write
    // HI/LO and pulse done in FIXUP. Reset aborts any operation without
    // touching HI/LO beyond clearing them.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= IDLE;
            step_cnt <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
            rs_raw   <= '0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            neg      <= 1'b0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        case (func_in)
                            FUNC_MULT, FUNC_MULTU: begin
                                mcand    <= magnitude(rs_data_in, signed_op);
                                mplier   <= magnitude(rt_data_in, signed_op);
                                neg      <= signed_op &
                                            (rs_data_in[WIDTH-1] ^ rt_data_in[WIDTH-1]);
                                prod     <= '0;
                                is_div   <= 1'b0;
                                step_cnt <= '0;
                                state    <= MUL;
                            end
                            FUNC_DIV, FUNC_DIVU: begin
                                quo      <= magnitude(rs_data_in, signed_op);
                                divisor  <= magnitude(rt_data_in, signed_op);
                                qneg     <= signed_op &
                                            (rs_data_in[WIDTH-1] ^ rt_data_in[WIDTH-1]);
                                rneg     <= signed_op & rs_data_in[WIDTH-1];
                                rem      <= '0;
                                rs_raw   <= rs_data_in;
                                div_zero <= (rt_data_in == '0);
                                is_div   <= 1'b1;
                                step_cnt <= '0;
                                state    <= DIV;
                            end
                            FUNC_MTHI: hi_out <= rs_data_in;
                            FUNC_MTLO: lo_out <= rs_data_in;
                            // mfhi/mflo are served by result_out; other funcs are ignored
                            FUNC_MFHI, FUNC_MFLO: ;
                            default: ;
                        endcase
                    end
                end

                MUL: begin
                    prod     <= {mul_sum, prod[WIDTH-1:1]};
                    mplier   <= mplier >> 1;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state <= FIXUP;
                    end
                end

                DIV: begin
                    if (div_fits) begin
                        rem <= div_diff;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= div_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state <= FIXUP;
                    end
                end

                FIXUP: begin
                    if (is_div) begin
                        if (div_zero) begin
                            // Divide by zero: all-ones quotient and the raw
                            // dividend as remainder. No sign fixup applies.
                            lo_out <= '1;
                            hi_out <= rs_raw;
                        end else begin
                            lo_out <= qneg ? -quo : quo;
                            hi_out <= rneg ? -rem : rem;
                        end
                    end else begin
                        {hi_out, lo_out} <= neg ? -prod : prod;
                    end
                    done_out <= 1'b1;
                    step_cnt <= '0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Self-checking bench for muldiv_ctrl. A constant vector table covers the
// documented corner results. Randomized operations are compared against a
// plain-arithmetic model of HI/LO. Hand-written sequences cover stalling,
// back-to-back starts and reset during an operation.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_muldiv_ctrl;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam int         LATENCY    = 33;

    logic        clk_in;
    logic        reset_in;
    logic        start_in;
    logic [5:0]  func_in;
    logic [31:0] rs_data_in;
    logic [31:0] rt_data_in;
    logic        busy_out;
    logic        stall_out;
    logic        done_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] result_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference HI/LO state
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    typedef struct {
        logic [5:0]  func;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vectors[13];

    muldiv_ctrl #(.WIDTH(32), .STEPS(32)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .start_in   (start_in),
        .func_in    (func_in),
        .rs_data_in (rs_data_in),
        .rt_data_in (rt_data_in),
        .busy_out   (busy_out),
        .stall_out  (stall_out),
        .done_out   (done_out),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .result_out (result_out)
    );

    // 20 ns clock. Inputs change just after the falling edge and outputs
    // are sampled there too, well away from the rising edge.
    initial begin
        clk_in = 1'b0;
        forever #10 clk_in = ~clk_in;
    end

    function automatic bit isMulDiv(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // HI/LO effect of one operation, from the arithmetic definition
    task automatic modelOp(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        longint          a;
        longint          b;
        longint          q;
        longint          r;
        longint unsigned p;
        a = {{32{rs[31]}}, rs};
        b = {{32{rt[31]}}, rt};
        case (f)
            FUNC_MULT: begin
                p = a * b;
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            FUNC_MULTU: begin
                p = {32'h0, rs} * {32'h0, rt};
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            FUNC_DIV, FUNC_DIVU: begin
                if (rt == 32'h0) begin
                    model_lo = 32'hFFFF_FFFF;
                    model_hi = rs;
                end else if (f == FUNC_DIV) begin
                    q = a / b;
                    r = a % b;
                    model_lo = q[31:0];
                    model_hi = r[31:0];
                end else begin
                    model_lo = rs / rt;
                    model_hi = rs % rt;
                end
            end
            FUNC_MTHI: model_hi = rs;
            FUNC_MTLO: model_lo = rs;
            default: ;
        endcase
    endtask

    // Present one instruction for a single cycle from the low clock phase,
    // follow it to completion and compare HI/LO and the move-from path.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] rs,
                                 input logic [31:0] rt);
        int cycles;
        start_in   = 1'b1;
        func_in    = f;
        rs_data_in = rs;
        rt_data_in = rt;
        #1;
        checkOutput("stall_idle", {31'b0, stall_out}, 32'd0);
        @(negedge clk_in);
        #1;
        start_in = 1'b0;
        modelOp(f, rs, rt);
        if (isMulDiv(f)) begin
            cycles = 0;
            while (busy_out && cycles < 100) begin
                cycles++;
                @(negedge clk_in);
                #1;
            end
            checkOutput("busy_cycles", cycles, LATENCY);
            checkOutput("done_pulse", {31'b0, done_out}, 32'd1);
        end else begin
            checkOutput("busy_quiet", {31'b0, busy_out}, 32'd0);
            checkOutput("done_quiet", {31'b0, done_out}, 32'd0);
        end
        checkOutput("hi", hi_out, model_hi);
        checkOutput("lo", lo_out, model_lo);
        func_in = FUNC_MFHI;
        #1;
        checkOutput("mfhi_result", result_out, model_hi);
        func_in = FUNC_MFLO;
        #1;
        checkOutput("mflo_result", result_out, model_lo);
    endtask

    initial begin
        int          stall_cycles;
        int          guard;
        int          done_seen;
        logic [5:0]  rand_func;
        logic [31:0] rand_rs;
        logic [31:0] rand_rt;
        logic [5:0]  func_pool[6];

        func_pool = '{FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO};

        vectors[0]  = '{FUNC_MTHI,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vectors[1]  = '{FUNC_MTLO,  32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0};
        vectors[2]  = '{FUNC_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vectors[3]  = '{FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vectors[4]  = '{FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vectors[5]  = '{FUNC_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vectors[6]  = '{FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vectors[7]  = '{FUNC_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vectors[8]  = '{FUNC_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vectors[9]  = '{FUNC_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vectors[10] = '{FUNC_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vectors[11] = '{FUNC_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vectors[12] = '{FUNC_MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};

        // Reset state
        reset_in   = 1'b1;
        start_in   = 1'b0;
        func_in    = FUNC_MFHI;
        rs_data_in = 32'h0;
        rt_data_in = 32'h0;
        repeat (2) @(negedge clk_in);
        #1;
        checkOutput("reset_hi", hi_out, 32'h0);
        checkOutput("reset_lo", lo_out, 32'h0);
        checkOutput("reset_busy", {31'b0, busy_out}, 32'd0);
        checkOutput("reset_done", {31'b0, done_out}, 32'd0);
        reset_in = 1'b0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        @(negedge clk_in);
        #1;

        // Constant vectors, issued back to back. Each one after a mult/div
        // starts on that operation's done cycle.
        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vectors[i].func, vectors[i].rs, vectors[i].rt);
            checkOutput($sformatf("vec%0d_hi", i), hi_out, vectors[i].exp_hi);
            checkOutput($sformatf("vec%0d_lo", i), lo_out, vectors[i].exp_lo);
        end

        // mflo arrives 5 cycles into a mult. It must stall until busy drops,
        // then return the new LO. A divu then starts on the done cycle.
        $display("[TB] stall sequence");
        start_in   = 1'b1;
        func_in    = FUNC_MULT;
        rs_data_in = 32'h0001_2345;
        rt_data_in = 32'hFFFF_0F0F;
        @(negedge clk_in);
        #1;
        start_in = 1'b0;
        modelOp(FUNC_MULT, 32'h0001_2345, 32'hFFFF_0F0F);
        repeat (4) @(negedge clk_in);
        #1;
        start_in = 1'b1;
        func_in  = FUNC_MFLO;
        #1;
        stall_cycles = 0;
        guard        = 0;
        while (busy_out && guard < 100) begin
            if (stall_out) stall_cycles++;
            guard++;
            @(negedge clk_in);
            #1;
        end
        checkOutput("stall_cycles", stall_cycles, LATENCY - 4);
        checkOutput("stall_released", {31'b0, stall_out}, 32'd0);
        checkOutput("stall_done", {31'b0, done_out}, 32'd1);
        checkOutput("stall_mflo", result_out, model_lo);
        start_in = 1'b0;
        applyStimulus(FUNC_DIVU, 32'h0000_0064, 32'h0000_0007);

        // Randomized operations against the arithmetic model
        $display("[TB] random operations");
        for (int i = 0; i < 30; i++) begin
            rand_func = func_pool[$urandom_range(0, 5)];
            rand_rs   = $urandom;
            case ($urandom_range(0, 3))
                0:       rand_rt = 32'h0;
                1:       rand_rt = $urandom_range(1, 300);
                2:       rand_rt = -$urandom_range(1, 300);
                default: rand_rt = $urandom;
            endcase
            applyStimulus(rand_func, rand_rs, rand_rt);
        end

        // Reset during a divide: HI/LO cleared and no done pulse afterwards
        $display("[TB] reset during divide");
        applyStimulus(FUNC_MTHI, 32'hAAAA_AAAA, 32'h0);
        applyStimulus(FUNC_MTLO, 32'hAAAA_AAAA, 32'h0);
        start_in   = 1'b1;
        func_in    = FUNC_DIV;
        rs_data_in = 32'h1234_5678;
        rt_data_in = 32'h0000_0005;
        @(negedge clk_in);
        #1;
        start_in = 1'b0;
        repeat (16) @(negedge clk_in);
        #1;
        reset_in = 1'b1;
        @(negedge clk_in);
        #1;
        checkOutput("abort_busy", {31'b0, busy_out}, 32'd0);
        checkOutput("abort_hi", hi_out, 32'h0);
        checkOutput("abort_lo", lo_out, 32'h0);
        reset_in  = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk_in);
            #1;
            if (done_out) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 32'd0);
        checkOutput("abort_hi_after", hi_out, 32'h0);
        checkOutput("abort_lo_after", lo_out, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair.
- Sits beside the ALU and is started by the decode stage for the R-type mult/div/mfhi/mflo/mthi/mtlo funcs.
- Runs a 32-step shift-add multiply or restoring divide, then a sign-fixup step.
- Holds the PC via stall_out when a HI/LO instruction arrives while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- STEPS, 32, iteration count; must equal WIDTH.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge
- reset_in  input  1  synchronous, active-high reset
- start_in  input  1  decoded R-type instruction targets this block this cycle
- func_in  input  6  R-type func field: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo
- rs_data_in  input  32  rs operand (multiplicand/dividend; mthi/mtlo source)
- rt_data_in  input  32  rt operand (multiplier/divisor)
- busy_out  output  1  operation in flight (state != IDLE)
- stall_out  output  1  combinational: start_in & busy_out; decode holds the PC and instruction
- done_out  output  1  one-cycle pulse when HI/LO take a mult/div result
- hi_out  output  32  HI register
- lo_out  output  32  LO register
- result_out  output  32  combinational: func_in[1] ? lo_out : hi_out (mfhi/mflo write-back data)

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: hi_out = 0, lo_out = 0, busy_out = 0, done_out = 0.
  - Internal state: state = IDLE, step counter = 0, accumulators = 0.
  - Reset mid-operation aborts the operation; no partial HI/LO write.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, start_in = 1 at edge E0:
  - mult/multu:
    - Latch |rs| and |rt| (raw values for multu).
    - Latch neg = rs[31]^rt[31] (signed only); clear the 64-bit accumulator.
    - Go to MUL with counter = 0.
  - div/divu:
    - Latch magnitudes.
    - Latch qneg = rs[31]^rt[31] and rneg = rs[31] (signed only); clear the remainder.
    - Go to DIV with counter = 0.
  - mthi/mtlo: hi/lo <= rs_data_in at E0; stay in IDLE; done_out not asserted.
  - mfhi/mflo: no state change; result_out is valid the same cycle.
  - Any other func: ignored.
- MUL: each edge performs one shift-add step and increments the counter. After step 32 (edge E32), go to FIXUP.
- DIV: each edge performs one restoring step (shift remainder, trial subtract, set quotient bit). After step 32 (E32), go to FIXUP.
- FIXUP (edge E33):
  - Apply negation: product if neg; quotient if qneg; remainder if rneg.
  - mult: {hi, lo} <= product.
  - div: lo <= quotient, hi <= remainder.
  - Return to IDLE; done_out = 1 for the cycle after E33.
- Latency and stall:
  - busy_out is high from the cycle after E0 through E33, i.e. 33 cycles.
  - Back-to-back start is accepted the first cycle busy_out = 0.
  - start_in while busy: stall_out = 1; the request is not accepted; func/operands are held by decode and re-presented.
- Divide by zero (rt = 0):
  - lo <= 0xFFFFFFFF, hi <= rs_data_in as latched; fixup negation is suppressed.
  - Latency is unchanged.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0 (wraps naturally; no trap).
- Simultaneous events:
  - reset_in has priority over start_in.
  - done_out and an accepted new start may coincide; the new op starts at that edge.
- All arithmetic is modulo 2^32 per register; the accumulator is 64-bit.

Test Plan:
- Reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 -> hi_out = 0x12345678, lo_out = 0x9ABCDEF0 the cycle after; mfhi result_out = 0x12345678 combinationally.
- mult rs = 0xFFFFFFFE (-2), rt = 0x00000003 -> busy_out high for exactly 33 cycles; done_out pulse; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
- multu rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- div rs = 0xFFFFFFF9 (-7), rt = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). divu 7/0 -> lo = 0xFFFFFFFF, hi = 7.
- mflo presented 5 cycles into a mult -> stall_out = 1 until busy_out falls; mflo then returns the new lo; a divu presented on the done_out cycle is accepted.
- reset_in asserted at step 17 of a div with hi/lo preloaded to 0xAAAAAAAA -> next cycle busy_out = 0, hi = lo = 0, and done_out never pulses.
